// File: rtl/motion_pkg.sv
// Shared widths, result record and FSM encodings for the motion target locator.
package motion_pkg;

  localparam int COUNT_W = 15;
  localparam int SUM_W   = 22;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_PUB
  } div_state_t;

  typedef struct packed {
    logic               target_valid;
    logic [X_W-1:0]     bbox_x_min;
    logic [X_W-1:0]     bbox_x_max;
    logic [Y_W-1:0]     bbox_y_min;
    logic [Y_W-1:0]     bbox_y_max;
    logic [X_W-1:0]     centroid_x;
    logic [Y_W-1:0]     centroid_y;
    logic [COUNT_W-1:0] count;
  } target_result_t;

endpackage

// File: rtl/motion_target_locator_seq_divider.sv
// Restoring divider producing one quotient bit per cycle; done pulses exactly
// DIVIDEND_W cycles after the start edge.
module seq_divider #(
  parameter int DIVIDEND_W = 22,
  parameter int DIVISOR_W  = 15,
  parameter int QUOT_W     = DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    rem_sh;
  logic [DIVISOR_W:0]    diff;

  // The partial remainder never exceeds 2*divisor-1, so the diff MSB is the borrow.
  always_comb begin
    rem_sh = {rem, quo[DIVIDEND_W-1]};
    diff   = rem_sh - {1'b0, dsr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dsr <= divisor;
        cnt <= CNT_W'(DIVIDEND_W);
      end else if (cnt != '0) begin
        if (!diff[DIVISOR_W]) begin
          rem <= diff[DIVISOR_W-1:0];
          quo <= {quo[DIVIDEND_W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[DIVISOR_W-1:0];
          quo <= {quo[DIVIDEND_W-2:0], 1'b0};
        end
        cnt  <= cnt - CNT_W'(1);
        done <= (cnt == CNT_W'(1));
      end
    end
  end

  assign quotient = quo[QUOT_W-1:0];

endmodule

// File: rtl/motion_target_locator.sv
// Reduces each motion-mask frame to bounding box, pixel count and centroid;
// division of one frame overlaps accumulation of the next.
module motion_target_locator
  import motion_pkg::*;
#(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pixel_valid,
  input  logic               motion_pixel,
  input  logic [X_W-1:0]     x_coord,
  input  logic [Y_W-1:0]     y_coord,
  output logic               result_valid,
  output logic               target_valid,
  output logic [X_W-1:0]     bbox_x_min,
  output logic [X_W-1:0]     bbox_x_max,
  output logic [Y_W-1:0]     bbox_y_min,
  output logic [Y_W-1:0]     bbox_y_max,
  output logic [X_W-1:0]     centroid_x,
  output logic [Y_W-1:0]     centroid_y,
  output logic [COUNT_W-1:0] pixel_count,
  output logic               busy,
  output logic               frame_dropped
);

  localparam logic [X_W-1:0] X_INIT = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'(HEIGHT - 1);

  acc_state_t state, state_next;
  div_state_t dstate, dstate_next;

  logic [COUNT_W-1:0] acc_count, nxt_count, hold_count;
  logic [SUM_W-1:0]   acc_sum_x, acc_sum_y, nxt_sum_x, nxt_sum_y;
  logic [X_W-1:0]     acc_x_min, acc_x_max, nxt_x_min, nxt_x_max;
  logic [Y_W-1:0]     acc_y_min, acc_y_max, nxt_y_min, nxt_y_max;
  logic [X_W-1:0]     hold_x_min, hold_x_max, quo_x;
  logic [Y_W-1:0]     hold_y_min, hold_y_max, quo_y;
  logic               pix_hit, end_hit, launch, drop, done_x, done_y;
  target_result_t     result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The end-of-frame pixel is folded into the nxt_* values before snapshotting.
  always_comb begin
    state_next = state;
    pix_hit    = (state == ACCUM) && pixel_valid && motion_pixel &&
                 (int'(x_coord) < WIDTH) && (int'(y_coord) < HEIGHT);
    end_hit    = (state == ACCUM) && frame_end;
    launch     = end_hit && !busy;
    drop       = end_hit && busy;
    nxt_count  = acc_count;
    nxt_sum_x  = acc_sum_x;
    nxt_sum_y  = acc_sum_y;
    nxt_x_min  = acc_x_min;
    nxt_x_max  = acc_x_max;
    nxt_y_min  = acc_y_min;
    nxt_y_max  = acc_y_max;
    if (pix_hit) begin
      if (acc_count != '1) nxt_count = acc_count + COUNT_W'(1);
      nxt_sum_x = acc_sum_x + SUM_W'(x_coord);
      nxt_sum_y = acc_sum_y + SUM_W'(y_coord);
      if (x_coord < acc_x_min) nxt_x_min = x_coord;
      if (x_coord > acc_x_max) nxt_x_max = x_coord;
      if (y_coord < acc_y_min) nxt_y_min = y_coord;
      if (y_coord > acc_y_max) nxt_y_max = y_coord;
    end
    if (frame_start)  state_next = ACCUM;
    else if (end_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || frame_start) begin
      acc_count <= '0;
      acc_sum_x <= '0;
      acc_sum_y <= '0;
      acc_x_min <= X_INIT;
      acc_x_max <= '0;
      acc_y_min <= Y_INIT;
      acc_y_max <= '0;
    end else if (state == ACCUM) begin
      acc_count <= nxt_count;
      acc_sum_x <= nxt_sum_x;
      acc_sum_y <= nxt_sum_y;
      acc_x_min <= nxt_x_min;
      acc_x_max <= nxt_x_max;
      acc_y_min <= nxt_y_min;
      acc_y_max <= nxt_y_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_count    <= '0;
      hold_x_min    <= '0;
      hold_x_max    <= '0;
      hold_y_min    <= '0;
      hold_y_max    <= '0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= drop;
      if (launch) begin
        hold_count <= nxt_count;
        hold_x_min <= nxt_x_min;
        hold_x_max <= nxt_x_max;
        hold_y_min <= nxt_y_min;
        hold_y_max <= nxt_y_max;
      end
    end
  end

  seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(COUNT_W), .QUOT_W(X_W)) div_x (
    .clk(clk), .reset(reset), .start(launch), .dividend(nxt_sum_x),
    .divisor(nxt_count), .quotient(quo_x), .done(done_x)
  );

  seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(COUNT_W), .QUOT_W(Y_W)) div_y (
    .clk(clk), .reset(reset), .start(launch), .dividend(nxt_sum_y),
    .divisor(nxt_count), .quotient(quo_y), .done(done_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dstate <= D_IDLE;
    else       dstate <= dstate_next;
  end

  always_comb begin
    dstate_next = dstate;
    busy        = (dstate != D_IDLE);
    case (dstate)
      D_IDLE:  if (launch) dstate_next = D_RUN;
      D_RUN:   if (done_x && done_y) dstate_next = D_PUB;
      D_PUB:   dstate_next = D_IDLE;
      default: dstate_next = D_IDLE;
    endcase
  end

  // Small targets still report their count, but geometry is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (dstate == D_PUB);
      if (dstate == D_PUB) begin
        result       <= '0;
        result.count <= hold_count;
        if (hold_count != '0 && int'(hold_count) >= MIN_PIXELS) begin
          result.target_valid <= 1'b1;
          result.bbox_x_min   <= hold_x_min;
          result.bbox_x_max   <= hold_x_max;
          result.bbox_y_min   <= hold_y_min;
          result.bbox_y_max   <= hold_y_max;
          result.centroid_x   <= quo_x;
          result.centroid_y   <= quo_y;
        end
      end
    end
  end

  assign target_valid = result.target_valid;
  assign bbox_x_min   = result.bbox_x_min;
  assign bbox_x_max   = result.bbox_x_max;
  assign bbox_y_min   = result.bbox_y_min;
  assign bbox_y_max   = result.bbox_y_max;
  assign centroid_x   = result.centroid_x;
  assign centroid_y   = result.centroid_y;
  assign pixel_count  = result.count;

endmodule

// File: tb/tb_motion_target_locator.sv
// Scoreboard bench for motion_target_locator: a reference model pushes expected
// results at frame_end and a monitor pops them when result_valid pulses.
module tb_motion_target_locator;

  localparam int MIN_PIX = 16;
  localparam int LAT     = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0, frame_end = 1'b0;
  logic        pixel_valid = 1'b0, motion_pixel = 1'b0;
  logic [7:0]  x_coord = '0;
  logic [6:0]  y_coord = '0;
  logic        result_valid, target_valid, busy, frame_dropped;
  logic [7:0]  bbox_x_min, bbox_x_max, centroid_x;
  logic [6:0]  bbox_y_min, bbox_y_max, centroid_y;
  logic [14:0] pixel_count;
  logic [60:0] act;

  typedef struct {
    int          cyc;
    logic [60:0] res;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, cyc = 0;
  int   m_cnt, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax;
  bit   in_frame = 1'b0;
  int   launch_cyc = -1000;
  int   drop_cyc = -1;

  motion_target_locator #(.WIDTH(160), .HEIGHT(120), .MIN_PIXELS(MIN_PIX)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .motion_pixel(motion_pixel), .x_coord(x_coord),
    .y_coord(y_coord), .result_valid(result_valid), .target_valid(target_valid),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max), .bbox_y_min(bbox_y_min),
    .bbox_y_max(bbox_y_max), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .pixel_count(pixel_count), .busy(busy), .frame_dropped(frame_dropped)
  );

  assign act = {target_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
                centroid_x, centroid_y, pixel_count};

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every result_valid must match the oldest queued expectation and its cycle.
  always @(posedge clk) begin
    #1;
    if (result_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result: result_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (act !== mon_e.res) begin
          errors++;
          $display("[TB] FAIL result_fields: got %h, expected %h", act, mon_e.res);
        end
        checks++;
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("[TB] FAIL result_latency: result at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
    if (frame_dropped || cyc == drop_cyc) begin
      checks++;
      if (frame_dropped !== (cyc == drop_cyc)) begin
        errors++;
        $display("[TB] FAIL frame_dropped: got %b at cycle %0d, expected %b", frame_dropped, cyc, cyc == drop_cyc);
      end
    end
  end

  // Drives one cycle and mirrors the expected accumulator behaviour.
  task automatic drive(input bit fs, input bit fe, input bit pv, input bit mp, input int x, input int y);
    int   c;
    exp_t e;
    @(negedge clk);
    frame_start  = fs;
    frame_end    = fe;
    pixel_valid  = pv;
    motion_pixel = mp;
    x_coord      = 8'(x);
    y_coord      = 7'(y);
    c = cyc + 1;
    if (in_frame && pv && mp && x < 160 && y < 120) begin
      m_cnt++;
      m_sx += x;
      m_sy += y;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
    if (in_frame && fe) begin
      if (c - launch_cyc <= LAT) begin
        drop_cyc = c;
      end else begin
        launch_cyc = c;
        e.cyc = c + LAT;
        if (m_cnt >= MIN_PIX)
          e.res = {1'b1, 8'(m_xmin), 8'(m_xmax), 7'(m_ymin), 7'(m_ymax),
                   8'(m_sx / m_cnt), 7'(m_sy / m_cnt), 15'(m_cnt)};
        else
          e.res = {46'b0, 15'(m_cnt)};
        exp_q.push_back(e);
      end
      in_frame = 1'b0;
    end
    if (fs) begin
      in_frame = 1'b1;
      m_cnt = 0; m_sx = 0; m_sy = 0;
      m_xmin = 159; m_xmax = 0; m_ymin = 119; m_ymax = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic block(input int x0, input int y0);
    for (int yy = y0; yy < y0 + 4; yy++)
      for (int xx = x0; xx < x0 + 4; xx++) drive(0, 0, 1, 1, xx, yy);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    idle(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (act !== 61'b0) begin
      errors++;
      $display("[TB] FAIL reset_results: got %h, expected 0", act);
    end
    checks++;
    if ({result_valid, busy, frame_dropped} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, expected 000", {result_valid, busy, frame_dropped});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single_pixel();
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 1, 10, 20);
    drive(0, 1, 0, 0, 0, 0);
    idle(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_end: got %b, expected 1", busy);
    end
    drain();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pixel_drain: pending %0d busy %b, expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_block();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 10, 10);
    drive(0, 0, 1, 0, 100, 100);
    block(40, 50);
    drive(0, 1, 0, 0, 0, 0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL block_drain: pending %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_scatter();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      drive(0, 0, 1, 1, $urandom_range(0, 159), $urandom_range(0, 119));
      drive(0, 0, 1, 1, $urandom_range(160, 255), $urandom_range(0, 119));
      drive(0, 0, 1, 1, $urandom_range(0, 159), $urandom_range(120, 127));
    end
    drive(0, 1, 1, 1, 159, 119);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scatter_drain: pending %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_below_min();
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 1, 0, 0, 0, 0);
    drain();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 1, 1, 70 + i, 30 + (i % 4));
    drive(0, 1, 0, 0, 0, 0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL below_min_drain: pending %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_restart();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, i, 0);
    drive(1, 0, 0, 0, 0, 0);
    block(120, 90);
    drive(0, 1, 0, 0, 0, 0);
    drain();
    drive(1, 0, 0, 0, 0, 0);
    block(100, 10);
    drive(1, 1, 1, 1, 5, 6);
    block(20, 30);
    idle(12);
    drive(0, 1, 0, 0, 0, 0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_drain: pending %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 0);
    block(60, 60);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 1, 2 + i, 3);
    idle(1);
    drive(0, 1, 0, 0, 0, 0);
    drain();
    idle(30);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_drain: pending %0d busy %b, expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0);
    block(30, 40);
    drive(0, 1, 0, 0, 0, 0);
    idle(10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (act !== 61'b0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: results %h valid %b busy %b, expected 0 0 0", act, result_valid, busy);
    end
    exp_q.delete();
    in_frame = 1'b0;
    launch_cyc = -1000;
    drop_cyc = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    block(140, 100);
    drive(0, 1, 1, 1, 145, 110);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_drain: pending %0d, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] motion_target_locator bench start");
    test_reset();
    test_single_pixel();
    test_block();
    test_scatter();
    test_below_min();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
